// File: rtl/pipelined_comparator.sv
// Single-register compare stage with valid/ready handshake on both sides.
// Per-outcome saturating counters and sticky flags track the results the consumer accepts.
module pipelined_comparator #(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic          signed_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          agb,
    output logic          alb,
    output logic          aeb,
    input  logic          clr_stats,
    output logic [CW-1:0] gt_cnt,
    output logic [CW-1:0] lt_cnt,
    output logic [CW-1:0] eq_cnt,
    output logic          sticky_gt,
    output logic          sticky_lt
);

    // Flag vectors are ordered {gt, lt, eq}; index 2 = gt, 1 = lt, 0 = eq.
    logic          valid_q, valid_d;
    logic [2:0]    flags_q, flags_d;
    logic [2:0]    cmp_flags;
    logic [CW-1:0] cnt_q [3];
    logic [1:0]    sticky_q;
    logic          in_xfer, out_xfer;

    assign in_ready = !valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = valid_q && out_ready;

    always_comb begin
        cmp_flags = 3'b000;
        if (a == b) begin
            cmp_flags = 3'b001;
        end else if (signed_mode) begin
            cmp_flags = ($signed(a) > $signed(b)) ? 3'b100 : 3'b010;
        end else begin
            cmp_flags = (a > b) ? 3'b100 : 3'b010;
        end
    end

    always_comb begin
        valid_d = valid_q;
        flags_d = flags_q;
        if (in_xfer) begin
            valid_d = 1'b1;
            flags_d = cmp_flags;
        end else if (out_xfer) begin
            valid_d = 1'b0;
            flags_d = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            flags_q <= 3'b000;
        end else begin
            valid_q <= valid_d;
            flags_q <= flags_d;
        end
    end

    // clr_stats beats a coincident output transfer.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst || clr_stats) begin
                    cnt_q[gi] <= '0;
                end else if (out_xfer && flags_q[gi] && (cnt_q[gi] != {CW{1'b1}})) begin
                    cnt_q[gi] <= cnt_q[gi] + 1'b1;
                end
            end
        end
        for (gi = 0; gi < 2; gi++) begin : g_sticky
            always_ff @(posedge clk) begin
                if (rst || clr_stats) begin
                    sticky_q[gi] <= 1'b0;
                end else if (out_xfer && flags_q[gi+1]) begin
                    sticky_q[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign out_valid = valid_q;
    assign agb       = flags_q[2];
    assign alb       = flags_q[1];
    assign aeb       = flags_q[0];
    assign gt_cnt    = cnt_q[2];
    assign lt_cnt    = cnt_q[1];
    assign eq_cnt    = cnt_q[0];
    assign sticky_gt = sticky_q[1];
    assign sticky_lt = sticky_q[0];

endmodule

// File: tb/tb_pipelined_comparator.sv
// Random and directed stimulus against a behavioural model of the comparator stage,
// checked every cycle on the falling edge, plus literal expectations for known cases.
module tb_pipelined_comparator;

    localparam int N  = 8;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, signed_mode, out_valid, out_ready;
    logic [N-1:0]  a, b;
    logic          agb, alb, aeb, clr_stats, sticky_gt, sticky_lt;
    logic [CW-1:0] gt_cnt, lt_cnt, eq_cnt;

    int checks = 0;
    int errors = 0;

    pipelined_comparator #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .agb(agb), .alb(alb), .aeb(aeb),
        .clr_stats(clr_stats), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt),
        .sticky_gt(sticky_gt), .sticky_lt(sticky_lt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: result register as a (valid, outcome) pair plus counts.
    bit m_live = 0;
    bit m_valid = 0;
    int m_res = 0;          // 1 = gt, 2 = lt, 3 = eq, 0 = none
    int m_gt = 0, m_lt = 0, m_eq = 0;
    bit m_sgt = 0, m_slt = 0;

    function automatic int value_of(input logic [N-1:0] v, input logic sm);
        if (sm && v[N-1]) return int'(v) - (1 << N);
        return int'(v);
    endfunction

    function automatic int outcome(input logic [N-1:0] x, input logic [N-1:0] y, input logic sm);
        int vx = value_of(x, sm);
        int vy = value_of(y, sm);
        if (vx > vy) return 1;
        if (vx < vy) return 2;
        return 3;
    endfunction

    always @(posedge clk) begin
        bit ixf, oxf;
        if (rst) begin
            m_live = 1; m_valid = 0; m_res = 0;
            m_gt = 0; m_lt = 0; m_eq = 0; m_sgt = 0; m_slt = 0;
        end else if (m_live) begin
            ixf = in_valid && (!m_valid || out_ready);
            oxf = m_valid && out_ready;
            if (clr_stats) begin
                m_gt = 0; m_lt = 0; m_eq = 0; m_sgt = 0; m_slt = 0;
            end else if (oxf) begin
                if (m_res == 1) begin m_gt = (m_gt < CMAX) ? m_gt + 1 : CMAX; m_sgt = 1; end
                if (m_res == 2) begin m_lt = (m_lt < CMAX) ? m_lt + 1 : CMAX; m_slt = 1; end
                if (m_res == 3) m_eq = (m_eq < CMAX) ? m_eq + 1 : CMAX;
            end
            if (ixf) begin
                m_valid = 1; m_res = outcome(a, b, signed_mode);
            end else if (oxf) begin
                m_valid = 0; m_res = 0;
            end
        end
    end

    // Compare process: every output, every cycle, once the model is live.
    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready",  int'(in_ready),  int'(!m_valid || out_ready));
            check("out_valid", int'(out_valid), int'(m_valid));
            check("agb",       int'(agb),       int'(m_res == 1));
            check("alb",       int'(alb),       int'(m_res == 2));
            check("aeb",       int'(aeb),       int'(m_res == 3));
            check("gt_cnt",    int'(gt_cnt),    m_gt);
            check("lt_cnt",    int'(lt_cnt),    m_lt);
            check("eq_cnt",    int'(eq_cnt),    m_eq);
            check("sticky_gt", int'(sticky_gt), int'(m_sgt));
            check("sticky_lt", int'(sticky_lt), int'(m_slt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; in_valid = 0; a = '0; b = '0; signed_mode = 0; out_ready = 0; clr_stats = 0;
        cyc(); cyc();
        rst = 0;
        check("reset out_valid", int'(out_valid), 0);
        check("reset in_ready", int'(in_ready), 1);
        check("reset counts", int'({gt_cnt, lt_cnt, eq_cnt}), 0);

        // Unsigned 0xF0 > 0x10
        in_valid = 1; a = 8'hF0; b = 8'h10; signed_mode = 0; out_ready = 1;
        cyc();
        check("u_f0_10 out_valid", int'(out_valid), 1);
        check("u_f0_10 agb", int'(agb), 1);
        in_valid = 0;
        cyc();
        check("u_f0_10 gt_cnt", int'(gt_cnt), 1);
        check("u_f0_10 drained", int'(out_valid), 0);

        // Signed -16 < 16
        in_valid = 1; signed_mode = 1;
        cyc();
        check("s_f0_10 alb", int'(alb), 1);
        in_valid = 0;
        cyc();
        check("s_f0_10 lt_cnt", int'(lt_cnt), 1);
        check("s_f0_10 sticky_lt", int'(sticky_lt), 1);

        // Stall: hold 5>3 while 3<5 waits at the input
        out_ready = 0; in_valid = 1; a = 8'd5; b = 8'd3; signed_mode = 0;
        cyc();
        a = 8'd3; b = 8'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall in_ready", int'(in_ready), 0);
            check("stall agb held", int'(agb), 1);
            cyc();
        end
        out_ready = 1;
        cyc();
        check("release second alb", int'(alb), 1);
        in_valid = 0;
        cyc();
        check("release drained", int'(out_valid), 0);
        check("release gt_cnt", int'(gt_cnt), 2);
        check("release lt_cnt", int'(lt_cnt), 2);

        // Saturation of eq_cnt at 3 with CW=2
        clr_stats = 1;
        cyc();
        clr_stats = 0; in_valid = 1; a = 8'h7; b = 8'h7;
        repeat (6) cyc();
        in_valid = 0;
        cyc();
        check("eq saturated", int'(eq_cnt), 3);
        in_valid = 1;
        cyc();
        clr_stats = 1;
        cyc();
        check("clr beats transfer", int'(eq_cnt), 0);
        check("clr keeps result", int'(aeb), 1);
        clr_stats = 0; in_valid = 0;
        cyc();

        // Reset while a result is stalled
        out_ready = 0; in_valid = 1; a = 8'h1; b = 8'h2;
        cyc();
        in_valid = 0; rst = 1;
        cyc();
        rst = 0;
        check("rst out_valid", int'(out_valid), 0);
        check("rst flags", int'({agb, alb, aeb}), 0);
        check("rst counts", int'({gt_cnt, lt_cnt, eq_cnt, sticky_gt, sticky_lt}), 0);
        check("rst in_ready", int'(in_ready), 1);

        // Random traffic in both modes
        for (int i = 0; i < 3000; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            signed_mode = $urandom_range(0, 1);
            a           = N'($urandom);
            b           = ($urandom_range(0, 3) == 0) ? a : N'($urandom);
            clr_stats   = ($urandom_range(0, 39) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 0; clr_stats = 0; in_valid = 0;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
